dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the processor's load/store port: accepts one word-addressed request at a time over a valid/ready handshake and answers it a fixed number of cycles later. It sits between the processor's dmem request outputs (address, data, write enable) and the word storage, replacing the zero-latency dmem with a stall-capable target. Stores commit at response time; loads return registered read data. A completed-transaction counter supports bench checking.

## Interface
- ADDR_WIDTH, 12, word address width; depth is 2^ADDR_WIDTH words
- DATA_WIDTH, 32, word width
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low: sampled low at a rising edge resets the block
- req_valid  in  1  request present; must hold with all req_* stable until accepted
- req_ready  out  1  block can accept this cycle
- req_wren  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_data  in  DATA_WIDTH  store data, ignored for loads
- resp_valid  out  1  one-cycle response pulse
- resp_wren  out  1  copy of accepted req_wren, valid while resp_valid=1
- resp_data  out  DATA_WIDTH  load data, or echoed store data
- done_count  out  16  number of completed responses, wraps 0xFFFF->0x0000

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Accept: rising edge with state IDLE and req_valid=1. Captures req_wren, req_addr, req_data; latency counter loaded with LATENCY-1.
- IDLE -> WAIT on accept when LATENCY > 1; IDLE -> RESP directly when LATENCY = 1.
- WAIT: counter decrements every edge; WAIT -> RESP on the edge where counter = 1.
- RESP: resp_valid=1 for exactly this cycle; RESP -> IDLE unconditionally on the next edge.
- Entering RESP (same edge): store writes captured data to mem[addr]; load registers mem[addr] into resp_data; store registers captured data into resp_data; done_count increments.
- resp_data and resp_wren hold their last values outside RESP.
- req_valid while req_ready=0 is ignored; no queuing, no request lost if the initiator holds it.
- Load following a store to the same address observes the stored value (store committed before the later request is accepted).
- Memory contents are not cleared by reset; undefined until written.

## Timing
- Request accepted at end of cycle 0 -> resp_valid high in cycle LATENCY -> req_ready high again in cycle LATENCY+1.
- Maximum throughput: one transaction per LATENCY+1 cycles.
- Reset values: state IDLE, req_ready=1 in the first cycle after reset, resp_valid=0, resp_wren=0, resp_data=0, done_count=0.
- Reset mid-operation: a pending request is discarded; a store whose RESP-entry edge coincides with or follows reset is not committed; done_count returns to 0.
- Reset during RESP: resp_valid low on the next cycle; the write already committed on RESP entry stands.
- All outputs are registered or decoded from state only; no combinational path from req_* to any output.

## Test plan
- Reset hold 2 cycles, release -> req_ready=1, resp_valid=0, resp_data=0, done_count=0.
- LATENCY=2: store addr 0x005 data 0xDEADBEEF accepted cycle 0 -> req_ready low cycles 1-2, resp_valid=1 and resp_wren=1 in cycle 2 only, resp_data=0xDEADBEEF, done_count=1; then load 0x005 -> resp_data=0xDEADBEEF, resp_wren=0, done_count=2.
- Back-to-back: req_valid held high with stores to 0x000..0x003 (data = addr+1) -> one accept every 3 cycles; loads of 0x000..0x003 return 1,2,3,4.
- Request changes while req_ready=0 are ignored: during WAIT drive store 0xFFF/0x12345678 -> no response, load 0xFFF later returns its prior value.
- Reset pulsed in cycle 1 after accepting store 0x010/0xCAFEF00D -> no resp_valid, done_count=0; load 0x010 does not return 0xCAFEF00D (previously written 0x0 returned).
- LATENCY=1 build: accept cycle 0 -> resp_valid cycle 1, req_ready cycle 2; 65536 transactions -> done_count wraps to 0x0000.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// Fixed-latency, single-outstanding data-memory target for the processor's
// load/store port. One word-addressed request is taken per valid/ready
// handshake and answered LATENCY cycles later with a one-cycle response pulse.
// Stores commit to the word array on the same edge the response is raised.
// Loads return registered read data.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_ni         synchronous active-low reset
//   req_valid_i    request present, held with req_* stable until accepted
//   req_ready_o    high while idle (block can accept)
//   req_wren_i     1 = store, 0 = load
//   req_addr_i     word address
//   req_data_i     store data (ignored for loads)
//   resp_valid_o   one-cycle response pulse
//   resp_wren_o    accepted req_wren, held outside the pulse
//   resp_data_o    load data or echoed store data, held outside the pulse
//   done_count_o   completed responses, wraps at 16 bits
module dmem_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_wren_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic                  resp_valid_o,
   output logic                  resp_wren_o,
   output logic [DATA_WIDTH-1:0] resp_data_o,
   output logic [15:0]           done_count_o
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  wren_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  resp_wren_q;
   logic [DATA_WIDTH-1:0] resp_data_q;
   logic [15:0]           done_q;

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   logic                  accept;
   logic                  enter_resp;
   logic                  op_wren;
   logic [ADDR_WIDTH-1:0] op_addr;
   logic [DATA_WIDTH-1:0] op_data;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               accept = 1'b1;
               cnt_d  = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY=1 the response edge is the accept edge, so the operation
   // must come straight from the request rather than the capture registers.
   always_comb begin
      op_wren = wren_q;
      op_addr = addr_q;
      op_data = data_q;
      if (accept) begin
         op_wren = req_wren_i;
         op_addr = req_addr_i;
         op_data = req_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wren_q      <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         resp_wren_q <= 1'b0;
         resp_data_q <= '0;
         done_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wren_q <= req_wren_i;
            addr_q <= req_addr_i;
            data_q <= req_data_i;
         end
         if (enter_resp) begin
            resp_wren_q <= op_wren;
            resp_data_q <= op_wren ? op_data : mem_q[op_addr];
            done_q      <= done_q + 16'd1;
         end
      end
   end

   // Storage is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk_i) begin
      if (rst_ni && enter_resp && op_wren) begin
         mem_q[op_addr] <= op_data;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign resp_wren_o  = resp_wren_q;
   assign resp_data_o  = resp_data_q;
   assign done_count_o = done_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        clk1 = 1'b0;
   always #5 clk = ~clk;
   always #1 clk1 = ~clk1;

   // LATENCY=2 instance
   logic        rst_n, rv, rw, rdy, pv, pw;
   logic [11:0] ra;
   logic [31:0] rd, pd;
   logic [15:0] dc;

   // LATENCY=1 instance
   logic        rst1_n, rv1, rw1, rdy1, pv1, pw1;
   logic [11:0] ra1;
   logic [31:0] rd1, pd1;
   logic [15:0] dc1;

   int total = 0;
   int bad   = 0;

   dmem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LATENCY(2)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(rv), .req_ready_o(rdy),
      .req_wren_i(rw), .req_addr_i(ra), .req_data_i(rd),
      .resp_valid_o(pv), .resp_wren_o(pw), .resp_data_o(pd), .done_count_o(dc)
   );

   dmem_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
      .clk_i(clk1), .rst_ni(rst1_n), .req_valid_i(rv1), .req_ready_o(rdy1),
      .req_wren_i(rw1), .req_addr_i(ra1), .req_data_i(rd1),
      .resp_valid_o(pv1), .resp_wren_o(pw1), .resp_data_o(pd1), .done_count_o(dc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick1;
      @(posedge clk1);
      @(negedge clk1);
   endtask

   // One transaction on the LATENCY=2 instance, checking the response.
   task automatic xact(input string tag, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
      int n;
      chk({tag, "_rdy"}, 32'(rdy), 32'd1);
      rv = 1'b1; rw = wr; ra = a; rd = d;
      tick;
      rv = 1'b0;
      n = 0;
      while (!pv && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_seen"}, 32'(pv), 32'd1);
      chk({tag, "_data"}, pd, exp);
      chk({tag, "_wren"}, 32'(pw), 32'(wr));
      tick;
   endtask

   initial begin
      logic [15:0] d0, pre;
      int n, cyc;
      rst_n = 1'b0; rv = 1'b0; rw = 1'b0; ra = '0; rd = '0;
      rst1_n = 1'b0; rv1 = 1'b0; rw1 = 1'b0; ra1 = '0; rd1 = '0;
      @(negedge clk);
      tick; tick;
      rst_n = 1'b1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_valid", 32'(pv), 32'd0);
      chk("rst_data", pd, 32'd0);
      chk("rst_wren", 32'(pw), 32'd0);
      chk("rst_count", 32'(dc), 32'd0);

      // Store with cycle-accurate timing checks
      rv = 1'b1; rw = 1'b1; ra = 12'h005; rd = 32'hDEADBEEF;
      tick;                          // cycle 1
      rv = 1'b0;
      chk("st_c1_rdy", 32'(rdy), 32'd0);
      chk("st_c1_vld", 32'(pv), 32'd0);
      tick;                          // cycle 2
      chk("st_c2_rdy", 32'(rdy), 32'd0);
      chk("st_c2_vld", 32'(pv), 32'd1);
      chk("st_c2_wren", 32'(pw), 32'd1);
      chk("st_c2_data", pd, 32'hDEADBEEF);
      chk("st_c2_cnt", 32'(dc), 32'd1);
      tick;                          // cycle 3
      chk("st_c3_rdy", 32'(rdy), 32'd1);
      chk("st_c3_vld", 32'(pv), 32'd0);
      chk("st_c3_hold", pd, 32'hDEADBEEF);
      chk("st_c3_hwren", 32'(pw), 32'd1);
      xact("ld5", 1'b0, 12'h005, 32'h0, 32'hDEADBEEF);
      chk("ld5_cnt", 32'(dc), 32'd2);

      // Back-to-back stores with valid held high: one accept every 3 cycles
      d0 = dc;
      rv = 1'b1; rw = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_rdy%0d", i), 32'(rdy), 32'd1);
         ra = 12'(i); rd = 32'(i + 1);
         tick;
         chk($sformatf("b2b_busy%0d", i), 32'(rdy), 32'd0);
         tick;
         chk($sformatf("b2b_vld%0d", i), 32'(pv), 32'd1);
         if (i == 3) rv = 1'b0;
         tick;
      end
      chk("b2b_cnt", 32'(dc - d0), 32'd4);
      for (int i = 0; i < 4; i++)
         xact($sformatf("b2b_ld%0d", i), 1'b0, 12'(i), 32'h0, 32'(i + 1));

      // Request changes while busy are ignored
      xact("pre_fff", 1'b1, 12'hFFF, 32'h0BADC0DE, 32'h0BADC0DE);
      d0 = dc;
      rv = 1'b1; rw = 1'b0; ra = 12'h000; rd = 32'h0;
      tick;                          // WAIT
      rw = 1'b1; ra = 12'hFFF; rd = 32'h12345678;
      tick;                          // RESP of the load
      chk("ign_data", pd, 32'd1);
      rv = 1'b0;
      tick; tick; tick;
      chk("ign_vld", 32'(pv), 32'd0);
      chk("ign_cnt", 32'(dc - d0), 32'd1);
      xact("ign_ld", 1'b0, 12'hFFF, 32'h0, 32'h0BADC0DE);

      // Reset on the commit edge discards the pending store
      xact("pre_010", 1'b1, 12'h010, 32'h0, 32'h0);
      rv = 1'b1; rw = 1'b1; ra = 12'h010; rd = 32'hCAFEF00D;
      tick;                          // cycle 1
      rv = 1'b0; rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("rst_mid_vld", 32'(pv), 32'd0);
      chk("rst_mid_cnt", 32'(dc), 32'd0);
      chk("rst_mid_rdy", 32'(rdy), 32'd1);
      tick; tick;
      chk("rst_mid_vld2", 32'(pv), 32'd0);
      xact("rst_ld", 1'b0, 12'h010, 32'h0, 32'h0);
      chk("rst_ld_cnt", 32'(dc), 32'd1);

      // LATENCY=1 instance: timing, then 16-bit wrap
      @(negedge clk1);
      tick1; tick1;
      rst1_n = 1'b1;
      chk("l1_rst_cnt", 32'(dc1), 32'd0);
      rv1 = 1'b1; rw1 = 1'b1; ra1 = 12'h003; rd1 = 32'hA5A5A5A5;
      chk("l1_c0_rdy", 32'(rdy1), 32'd1);
      tick1;                         // cycle 1
      chk("l1_c1_vld", 32'(pv1), 32'd1);
      chk("l1_c1_rdy", 32'(rdy1), 32'd0);
      chk("l1_c1_data", pd1, 32'hA5A5A5A5);
      chk("l1_c1_cnt", 32'(dc1), 32'd1);
      tick1;                         // cycle 2
      chk("l1_c2_rdy", 32'(rdy1), 32'd1);
      chk("l1_c2_vld", 32'(pv1), 32'd0);
      n = 1; cyc = 0; pre = '0;
      while (n < 65536 && cyc < 140000) begin
         tick1;
         cyc++;
         if (pv1) begin
            n++;
            if (n == 65535) pre = dc1;
            if (n == 65536) rv1 = 1'b0;
         end
      end
      chk("l1_ntx", 32'(n), 32'd65536);
      chk("l1_pre_wrap", 32'(pre), 32'h0000FFFF);
      chk("l1_wrap", 32'(dc1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
